twiddle_fetch: RTL and testbench

// Read-side controller for the registered twiddle ROM (2-cycle read latency, no enable).
// On start, generates base + i*stride addresses for len words and absorbs the ROM latency.

---
 rtl/twiddle_fetch.sv | 212 +++++++++++++++++++++
 tb/tb_twiddle_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_fetch
// Description : Read-side controller for a registered twiddle ROM with a
//               2-cycle read latency. Generates base + i*stride addresses,
//               tracks in-flight reads, buffers returned words in a small
//               FIFO and streams them out over valid/ready with last/done.
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_fetch #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic [DATA_WIDTH-1:0] o_tw_data,
    output logic                  o_tw_valid,
    input  logic                  i_tw_ready,
    output logic                  o_tw_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int c_CW = $clog2(FIFO_DEPTH + 1);                 // occupancy counter width
    localparam int c_SW = c_CW + 2;                               // credit sum width
    localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_LEN_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_LEN_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issued;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_issue_v;
    logic                  r_issue_last;
    logic                  r_p1;
    logic                  r_p1_last;
    logic                  r_p2;
    logic                  r_p2_last;
    logic                  r_busy;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];
    logic [c_PW-1:0]       r_wr;
    logic [c_PW-1:0]       r_rd;
    logic [c_CW-1:0]       r_count;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_head_last;
    logic [c_CW-1:0]       w_occ;
    logic [c_SW-1:0]       w_need;
    logic                  w_credit;
    logic                  w_more;
    logic                  w_final_issue;

    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid & i_tw_ready;
    assign w_push        = r_p2;
    assign w_head_last   = r_mem_last[r_rd];

    // Occupancy after this cycle's pop: a slot freed now can be reused by the
    // word issued next cycle, which is what keeps depth 4 bubble-free.
    assign w_occ         = r_count - c_CW'(w_pop);
    assign w_need        = c_SW'(r_issue_v) + c_SW'(r_p1) + c_SW'(r_p2)
                         + c_SW'(w_occ) + c_SW'(1);
    assign w_credit      = (w_need <= c_SW'(FIFO_DEPTH));
    assign w_more        = (r_issued != r_len);
    assign w_final_issue = ((r_issued + c_LEN_ONE) == r_len);

    assign o_rom_addr    = r_rom_addr;
    assign o_tw_data     = r_mem_data[r_rd];
    assign o_tw_valid    = w_valid;
    assign o_tw_last     = w_valid & w_head_last;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    // Job sequencer: address generation, issue credit, and busy/done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_issued     <= '0;
            r_stride     <= '0;
            r_next_addr  <= '0;
            r_rom_addr   <= '0;
            r_issue_v    <= 1'b0;
            r_issue_last <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_issue_v    <= 1'b0;
                    r_issue_last <= 1'b0;
                    if (i_start) begin
                        r_len    <= i_len;
                        r_stride <= i_stride;
                        if (i_len == c_LEN_ZERO) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            // First address goes out in the very next cycle
                            r_state      <= S_FETCH;
                            r_busy       <= 1'b1;
                            r_rom_addr   <= i_base_addr;
                            r_next_addr  <= i_base_addr + i_stride;
                            r_issued     <= c_LEN_ONE;
                            r_issue_v    <= 1'b1;
                            r_issue_last <= (i_len == c_LEN_ONE);
                        end
                    end
                end
                S_FETCH: begin
                    if (w_more && w_credit) begin
                        r_rom_addr   <= r_next_addr;
                        r_next_addr  <= r_next_addr + r_stride;
                        r_issued     <= r_issued + c_LEN_ONE;
                        r_issue_v    <= 1'b1;
                        r_issue_last <= w_final_issue;
                        if (w_final_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_issue_v    <= 1'b0;
                        r_issue_last <= 1'b0;
                        if (!w_more) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_issue_v    <= 1'b0;
                    r_issue_last <= 1'b0;
                    if (w_pop && w_head_last) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_issue_v    <= 1'b0;
                    r_issue_last <= 1'b0;
                    r_done       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // ROM latency tracking: valid/last tags follow each issued address by two cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1      <= 1'b0;
            r_p1_last <= 1'b0;
            r_p2      <= 1'b0;
            r_p2_last <= 1'b0;
        end else begin
            r_p1      <= r_issue_v;
            r_p1_last <= r_issue_v & r_issue_last;
            r_p2      <= r_p1;
            r_p2_last <= r_p1 & r_p1_last;
        end
    end

    // Return buffer: push from the ROM pipe, pop on transfer; both may happen together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr] <= i_rom_data;
                r_mem_last[r_wr] <= r_p2_last;
                r_wr <= (r_wr == c_PW'(FIFO_DEPTH - 1)) ? '0 : r_wr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == c_PW'(FIFO_DEPTH - 1)) ? '0 : r_rd + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_fetch
// Description : Scoreboard bench for twiddle_fetch with a 2-cycle ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_fetch;

    localparam int DW = 24;
    localparam int AW = 12;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [AW:0]   len;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] rom_s1;
    logic [DW-1:0] tw_data;
    logic          tw_valid;
    logic          tw_ready;
    logic          tw_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    twiddle_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_stride    (stride),
        .i_len       (len),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_tw_data   (tw_data),
        .o_tw_valid  (tw_valid),
        .i_tw_ready  (tw_ready),
        .o_tw_last   (tw_last),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Registered ROM, two-cycle latency, ROM[i] = i
    always @(posedge clk) begin
        rom_s1   <= {{(DW-AW){1'b0}}, rom_addr};
        rom_data <= rom_s1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int rmode    = 0;
    int first_valid_rel;
    int last_rel;
    int done_cnt;
    int done_rel;

    logic [DW:0]   sb_q [$];
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc - t0);
        end
    endtask

    // Monitor: scoreboard pops on each transfer, stall-hold checks, done tracking
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {31'd0, tw_valid}, 32'd1);
                    check("hold_data", {8'd0, tw_data}, {8'd0, prev_data});
                    check("hold_last", {31'd0, tw_last}, {31'd0, prev_last});
                end
                if (tw_valid && first_valid_rel < 0) first_valid_rel = cyc - t0;
                if (tw_valid && tw_ready) begin
                    if (sb_q.size() == 0) begin
                        check("extra_word", {8'd0, tw_data}, 32'hFFFF_FFFF);
                    end else begin
                        logic [DW:0] e;
                        e = sb_q.pop_front();
                        check("tw_data", {8'd0, tw_data}, {8'd0, e[DW-1:0]});
                        check("tw_last", {31'd0, tw_last}, {31'd0, e[DW]});
                    end
                    if (tw_last) last_rel = cyc - t0;
                end
                prev_stall = tw_valid & ~tw_ready;
                prev_data  = tw_data;
                prev_last  = tw_last;
                if (done) begin
                    done_cnt++;
                    done_rel = cyc - t0;
                end
            end
        end
    end

    // Consumer ready pattern, updated early in every cycle
    initial begin
        tw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                1:       tw_ready = !((cyc - t0) >= 3 && (cyc - t0) <= 15);
                2:       tw_ready = 1'($urandom_range(0, 1));
                default: tw_ready = 1'b1;
            endcase
        end
    end

    task automatic push_exp(input int b, input int s, input int n);
        for (int i = 0; i < n; i++) begin
            logic [DW:0] e;
            e = '0;
            e[AW-1:0] = AW'((b + i * s) % (1 << AW));
            e[DW]     = (i == n - 1);
            sb_q.push_back(e);
        end
    endtask

    // Pulse start for one cycle (cycle 0); afterwards it is cycle 1
    task automatic start_job(input int b, input int s, input int n);
        @(posedge clk);
        #1;
        first_valid_rel = -1;
        last_rel  = -1;
        done_cnt  = 0;
        done_rel  = -1;
        start     = 1'b1;
        base_addr = AW'(b);
        stride    = AW'(s);
        len       = (AW+1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc - 1;
    endtask

    task automatic wait_rel(input int n);
        while ((cyc - t0) < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({name, "_done_once"}, done_cnt, 1);
        check({name, "_sb_empty"}, sb_q.size(), 0);
        check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        stride = '0;
        len = '0;
        first_valid_rel = -1;
        last_rel = -1;
        done_cnt = 0;
        done_rel = -1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
        check("rst_tw_valid", {31'd0, tw_valid}, 32'd0);
        check("rst_tw_data", {8'd0, tw_data}, 32'd0);
        check("rst_tw_last", {31'd0, tw_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // 1: basic streaming latency
        rmode = 0;
        push_exp(0, 1, 8);
        start_job(0, 1, 8);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        check("t1_addr_c1", {20'd0, rom_addr}, 32'd0);
        wait_done("t1", 100);
        check("t1_first_valid", first_valid_rel, 4);
        check("t1_last_cycle", last_rel, 11);
        check("t1_done_cycle", done_rel, 12);

        // 2: address wrap
        push_exp(4094, 1, 4);
        start_job(4094, 1, 4);
        for (int n = 1; n <= 4; n++) begin
            wait_rel(n);
            check("t2_rom_addr", {20'd0, rom_addr}, (4094 + n - 1) % 4096);
        end
        wait_done("t2", 100);

        // 3: long stall, credit limit
        rmode = 1;
        push_exp(0, 512, 8);
        start_job(0, 512, 8);
        wait_rel(12);
        check("t3_stall_addr", {20'd0, rom_addr}, 32'd1536);
        check("t3_stall_valid", {31'd0, tw_valid}, 32'd1);
        check("t3_stall_data", {8'd0, tw_data}, 32'd0);
        wait_done("t3", 200);
        rmode = 0;

        // 4: random backpressure
        rmode = 2;
        push_exp(100, 37, 64);
        start_job(100, 37, 64);
        wait_done("t4", 1000);
        rmode = 0;

        // 5a: zero-length job
        start_job(0, 1, 0);
        check("t5_done_c1", {31'd0, done}, 32'd1);
        check("t5_busy_c1", {31'd0, busy}, 32'd0);
        for (int n = 2; n <= 4; n++) begin
            wait_rel(n);
            check("t5_valid_low", {31'd0, tw_valid}, 32'd0);
            check("t5_busy_low", {31'd0, busy}, 32'd0);
        end
        check("t5_done_once", done_cnt, 1);

        // 5b: start during a job is ignored
        push_exp(200, 3, 16);
        start_job(200, 3, 16);
        wait_rel(5);
        start = 1'b1;
        base_addr = AW'(999);
        stride = AW'(1);
        len = (AW+1)'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t5b", 200);

        // 6: reset mid-job
        push_exp(300, 1, 16);
        start_job(300, 1, 16);
        wait_rel(8);
        rst = 1'b1;
        #1;
        check("t6_rst_addr", {20'd0, rom_addr}, 32'd0);
        check("t6_rst_valid", {31'd0, tw_valid}, 32'd0);
        check("t6_rst_data", {8'd0, tw_data}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt, 0);
        check("t6_post_valid", {31'd0, tw_valid}, 32'd0);
        push_exp(7, 5, 4);
        start_job(7, 5, 4);
        wait_done("t6", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
